regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two requesters: pipeline writeback (WB) and the network interface (NI) delivering received packet words into registers.
- WB has priority by default. NI writes are buffered in a small FIFO.
- A starvation/full guard stalls the pipeline and drains the NI FIFO.
- Sits between the writeback stage / NI receive path and the decode-stage register file write inputs.

---
 rtl/regfile_write_arbiter_if.sv | 42 ++++
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Bundle of request and response signals around the register
//               file write arbiter.
//   master : requester side (writeback stage, NI receive path)
//   slave  : arbiter side
//   wb_we/wb_rd/wb_wd     writeback write request, address, data
//   ni_valid/ni_rd/ni_wd  NI write offer, address, data
//   ni_ready              arbiter can take an NI write this cycle
//   wr_en/wr_addr/wr_data registered register file write port
//   stall_pipe            pipeline stall while NI queue drains
//   ni_count              NI queue occupancy (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 4
);
  logic                     wb_we;
  logic [4:0]               wb_rd;
  logic [31:0]              wb_wd;
  logic                     ni_valid;
  logic [4:0]               ni_rd;
  logic [31:0]              ni_wd;
  logic                     ni_ready;
  logic                     wr_en;
  logic [4:0]               wr_addr;
  logic [31:0]              wr_data;
  logic                     stall_pipe;
  logic [$clog2(DEPTH):0]   ni_count;

  modport master (
    output wb_we, wb_rd, wb_wd, ni_valid, ni_rd, ni_wd,
    input  ni_ready, wr_en, wr_addr, wr_data, stall_pipe, ni_count
  );

  modport slave (
    input  wb_we, wb_rd, wb_wd, ni_valid, ni_rd, ni_wd,
    output ni_ready, wr_en, wr_addr, wr_data, stall_pipe, ni_count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the single register file write port between pipeline
//               writeback (priority) and the NI receive path (queued in a
//               small FIFO). A full queue or a starved queue head forces a
//               drain phase that stalls the pipeline.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : regfile_write_arbiter_if.slave (requests in, write port out)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  regfile_write_arbiter_if.slave   bus
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [c_SW-1:0] c_SLIM = c_SW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  state_t            r_state;
  logic [4:0]        r_fifo_rd [DEPTH];
  logic [31:0]       r_fifo_wd [DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [c_SW-1:0]   r_starve;
  logic              r_wr_en;
  logic [4:0]        r_wr_addr;
  logic [31:0]       r_wr_data;

  logic w_ready;
  logic w_push;
  logic w_empty;
  logic w_grant_wb;
  logic w_grant_ni;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < c_FULL) && (r_state == ST_IDLE);
  // Writes to r0 are architecturally void: accepted on the handshake but dropped.
  assign w_push  = bus.ni_valid && w_ready && (bus.ni_rd != 5'd0);

  // The pipeline holds its request while stalled, so WB is ignored in FORCE.
  assign w_grant_wb = (r_state == ST_IDLE) && bus.wb_we && (bus.wb_rd != 5'd0);
  assign w_grant_ni = !w_grant_wb && !w_empty;

  assign bus.ni_ready   = w_ready;
  assign bus.stall_pipe = (r_state == ST_FORCE);
  assign bus.ni_count   = r_count;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;

  // Queue storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr] <= bus.ni_rd;
      r_fifo_wd[r_wr_ptr] <= bus.ni_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_grant_ni) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_grant_ni})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Starvation counter only runs while IDLE with an ungranted, non-empty queue.
      if ((r_state == ST_FORCE) || w_grant_ni || w_empty) begin
        r_starve <= '0;
      end else if (r_starve != c_SLIM) begin
        r_starve <= r_starve + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if ((r_count == c_FULL) || (r_starve == c_SLIM)) begin
            r_state <= ST_FORCE;
          end
        end
        ST_FORCE: begin
          if (w_empty) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      r_wr_en <= w_grant_wb || w_grant_ni;
      if (w_grant_wb) begin
        r_wr_addr <= bus.wb_rd;
        r_wr_data <= bus.wb_wd;
      end else if (w_grant_ni) begin
        r_wr_addr <= r_fifo_rd[r_rd_ptr];
        r_wr_data <= r_fifo_wd[r_rd_ptr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Scoreboard bench for regfile_write_arbiter. A queue-based
//               reference model predicts per-cycle status and the next
//               write port value; a monitor compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    logic        ready;
    logic        stall;
    logic [31:0] count;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb[$];

  // Reference model state
  bit          m_force;
  int          m_starve;
  logic [36:0] m_q[$];
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  // Last driven WB request (held while stalled)
  logic        h_we;
  logic [4:0]  h_rd;
  logic [31:0] h_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_force  = 1'b0;
    m_starve = 0;
    m_q.delete();
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic drive_idle();
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_wd = '0;
    bus.ni_valid = 1'b0; bus.ni_rd = '0; bus.ni_wd = '0;
    h_we = 1'b0; h_rd = '0; h_wd = '0;
  endtask

  // One clock cycle of stimulus plus reference prediction.
  task automatic cyc(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                     input logic nv, input logic [4:0] nrd, input logic [31:0] nwd);
    exp_t e;
    bit   popped;
    bit   nxt_force;
    int   qn;
    @(negedge clk);
    if (m_force) begin
      we = h_we; rd = h_rd; wd = h_wd;
    end
    h_we = we; h_rd = rd; h_wd = wd;
    bus.wb_we = we; bus.wb_rd = rd; bus.wb_wd = wd;
    bus.ni_valid = nv; bus.ni_rd = nrd; bus.ni_wd = nwd;

    qn      = m_q.size();
    e.ready = (qn < DEPTH) && !m_force;
    e.stall = m_force;
    e.count = qn;
    popped  = 1'b0;
    if (!m_force && we && rd != 5'd0) begin
      m_addr = rd; m_data = wd; e.en = 1'b1;
    end else if (qn > 0) begin
      {m_addr, m_data} = m_q[0]; e.en = 1'b1; popped = 1'b1;
    end else begin
      e.en = 1'b0;
    end
    e.addr = m_addr;
    e.data = m_data;

    if (!m_force) nxt_force = (qn == DEPTH) || (m_starve == STARVE_LIMIT);
    else          nxt_force = (qn != 0);

    if (m_force || popped || qn == 0) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;

    if (popped) void'(m_q.pop_front());
    if (nv && e.ready && nrd != 5'd0) m_q.push_back({nrd, nwd});
    m_force = nxt_force;
    sb.push_back(e);
  endtask

  // Monitor: status sampled in the low phase, write port after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ni_ready",   32'(bus.ni_ready),   32'(e.ready));
        chk("stall_pipe", 32'(bus.stall_pipe), 32'(e.stall));
        chk("ni_count",   32'(bus.ni_count),   e.count);
        @(posedge clk);
        #1;
        chk("wr_en",   32'(bus.wr_en),   32'(e.en));
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", bus.wr_data,      e.data);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_wr_en"},    32'(bus.wr_en),      32'd0);
    chk({tag, "_stall"},    32'(bus.stall_pipe), 32'd0);
    chk({tag, "_count"},    32'(bus.ni_count),   32'd0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr),    32'd0);
    chk({tag, "_wr_data"},  bus.wr_data,         32'd0);
  endtask

  initial begin
    int guard;
    drive_idle();
    model_reset();

    // 1. Reset held with a WB request present
    bus.wb_we = 1'b1; bus.wb_rd = 5'd6; bus.wb_wd = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_reset_state("rst_hold");
    end
    drive_idle();
    rst = 1'b1;
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // 2. WB only, then a WB to r0
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0);
    cyc(1, 0, 32'hCAFEF00D, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // 3. Contention: WB keeps the port, NI follows once WB idles
    cyc(1, 3, 32'hA0000001, 1, 7, 32'h11111111);
    cyc(1, 3, 32'hA0000002, 0, 0, 0);
    cyc(1, 3, 32'hA0000003, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    // 4. Queue fills under continuous WB, forcing a drain
    for (int i = 1; i <= 4; i++) cyc(1, 20, 32'hB0000000 + i, 1, 5'(i), 32'hC0000000 + i);
    repeat (10) cyc(1, 20, 32'hB00000FF, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // 5. Starvation of a single queued NI write
    cyc(1, 12, 32'hD0000000, 1, 9, 32'h99999999);
    repeat (15) cyc(1, 12, 32'hD0000001, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // 6. Reset in the middle of a drain
    for (int i = 1; i <= 4; i++) cyc(1, 21, 32'hE0000000 + i, 1, 5'(i + 10), 32'hF0000000 + i);
    guard = 0;
    while (!(m_force && m_q.size() == 3) && guard < 20) begin
      cyc(1, 21, 32'hE00000FF, 0, 0, 0);
      guard++;
    end
    chk("reach_drain_cnt3", 32'(guard < 20), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(negedge clk);
    drive_idle();
    model_reset();
    rst = 1'b1;
    repeat (4) cyc(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    repeat (DEPTH + 4) cyc(0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
